// File: rtl/alu_div_pkg.sv
// rtl/alu_div_pkg.sv - shared types and constants for the sequential divider
package alu_div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } div_state_e;

  localparam int          DIV_ITER   = 32;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/alu_add_sub.sv
// rtl/alu_add_sub.sv - ripple adder/subtractor with carry out, shared with the ALU
module alu_add_sub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH-1:0] b_eff;

  // Subtract as a + ~b + 1; carry out set means no borrow (a >= b unsigned).
  assign b_eff        = sub ? ~b : b;
  assign {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

endmodule

// File: rtl/alu_div_seq.sv
// rtl/alu_div_seq.sv - RV32M DIV/DIVU/REM/REMU restoring divider, one quotient bit per cycle
module alu_div_seq
  import alu_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result
);

  localparam int             CNT_W    = $clog2(DIV_ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

  div_state_e       state, state_next;
  div_op_e          op_q;
  logic [WIDTH-1:0] a_q, b_q, quo_q, rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             q_neg_q, r_neg_q, special_q;

  logic             signed_op, a_neg, b_neg, div_zero, overflow;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] trial;
  logic             trial_carry, accept;
  logic             is_rem, fix_neg;
  logic [WIDTH-1:0] fix_val;

  assign signed_op = ~op_q[0];
  assign a_neg     = signed_op & a_q[WIDTH-1];
  assign b_neg     = signed_op & b_q[WIDTH-1];
  assign abs_a     = a_neg ? -a_q : a_q;
  assign abs_b     = b_neg ? -b_q : b_q;
  assign div_zero  = (b_q == '0);
  assign overflow  = signed_op && (a_q == INT_MIN) && (b_q == '1);

  // In CALC, b_q holds the absolute divisor loaded during PREP.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign accept    = rem_shift[WIDTH] | trial_carry;

  alu_add_sub #(.WIDTH(WIDTH)) u_trial_sub (
    .a     (rem_shift[WIDTH-1:0]),
    .b     (b_q),
    .sub   (1'b1),
    .sum   (trial),
    .carry (trial_carry)
  );

  assign is_rem  = op_q[1];
  assign fix_val = is_rem ? rem_q : quo_q;
  assign fix_neg = (is_rem ? r_neg_q : q_neg_q) & ~special_q;

  assign o_busy = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (i_start) state_next = PREP;
      PREP: state_next = (div_zero || overflow) ? FIX : CALC;
      CALC: if (cnt_q == CNT_LAST) state_next = FIX;
      FIX:  state_next = DONE;
      // DONE spans two cycles: the first raises o_valid, the second retires.
      DONE: if (o_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      op_q      <= DIV;
      a_q       <= '0;
      b_q       <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      special_q <= 1'b0;
      o_valid   <= 1'b0;
      o_result  <= '0;
    end else begin
      state   <= state_next;
      o_valid <= (state == DONE) && !o_valid;
      case (state)
        IDLE: begin
          if (i_start) begin
            a_q  <= i_a;
            b_q  <= i_b;
            op_q <= div_op_e'(i_op);
          end
        end
        PREP: begin
          q_neg_q <= a_neg ^ b_neg;
          r_neg_q <= a_neg;
          cnt_q   <= '0;
          if (div_zero) begin
            quo_q     <= DIV_ZERO_Q;
            rem_q     <= a_q;
            special_q <= 1'b1;
          end else if (overflow) begin
            quo_q     <= INT_MIN;
            rem_q     <= '0;
            special_q <= 1'b1;
          end else begin
            quo_q     <= abs_a;
            rem_q     <= '0;
            b_q       <= abs_b;
            special_q <= 1'b0;
          end
        end
        CALC: begin
          rem_q <= accept ? trial : rem_shift[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], accept};
          cnt_q <= cnt_q + 1'b1;
        end
        FIX: o_result <= fix_neg ? -fix_val : fix_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_seq.sv
// tb/tb_alu_div_seq.sv - table-driven scoreboard bench for alu_div_seq
module tb_alu_div_seq;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [1:0]  i_op = 2'b00;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic        o_busy, o_valid;
  logic [31:0] o_result;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  alu_div_seq #(.WIDTH(32)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (i_start),
    .i_op     (i_op),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_busy   (o_busy),
    .o_valid  (o_valid),
    .o_result (o_result)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n && o_valid) begin
      if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
      else check("result", o_result, exp_q.pop_front());
    end
  end

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      2'b01: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b11: return (b == 0) ? a : a % b;
      2'b00: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      default: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    if (b == 0) return 3;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 3;
    return 35;
  endfunction

  // Launch at E0; inj_at pulses a fresh start at that edge, rst_at aborts at that edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input int inj_at,
                        input int rst_at);
    int first, nval;
    bit done;
    first = -1;
    nval  = 0;
    done  = 1'b0;
    @(negedge i_clk);
    i_op = op;
    i_a = a;
    i_b = b;
    i_start = 1'b1;
    if (rst_at == 0) exp_q.push_back(exp);
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0;
    i_a = $urandom;
    i_b = $urandom;
    i_op = 2'($urandom_range(0, 3));
    check("busy_after_e0", {31'd0, o_busy}, 32'd1);
    for (int k = 1; k <= 60 && !done; k++) begin
      if (k == inj_at) begin
        i_start = 1'b1;
        i_op = 2'b01;
        i_a = 32'd5;
        i_b = 32'd1;
      end
      @(posedge i_clk);
      if (k == rst_at) begin
        #1 i_rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_result", o_result, 32'd0);
        done = 1'b1;
      end else begin
        @(negedge i_clk);
        if (k == inj_at) i_start = 1'b0;
        if (o_valid) begin
          if (first < 0) first = k;
          nval++;
        end
        if (!o_busy) done = 1'b1;
      end
    end
    if (rst_at == 0) begin
      check("completed", {31'd0, done}, 32'd1);
      check("valid_edge", first, lat);
      check("valid_count", nval, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{2'b01, 32'd100, 32'd7, 32'd14, 35});
    vecs.push_back('{2'b11, 32'd100, 32'd7, 32'd2, 35});
    vecs.push_back('{2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35});
    vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35});
    vecs.push_back('{2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 35});
    vecs.push_back('{2'b00, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 32'd4, 35});
    vecs.push_back('{2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 3});
    vecs.push_back('{2'b11, 32'd5, 32'd0, 32'd5, 3});
    vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 3});
    vecs.push_back('{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 3});
    vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 3});
    vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 35});
    vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 35});
    vecs.push_back('{2'b01, 32'd3, 32'h8000_0000, 32'd0, 35});
    vecs.push_back('{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 35});
    vecs.push_back('{2'b00, 32'h8000_0000, 32'd1, 32'h8000_0000, 35});
    for (int i = 0; i < 6; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom >> $urandom_range(0, 31);
      vecs.push_back('{op, a, b, model(op, a, b), model_lat(op, a, b)});
    end

    repeat (3) @(negedge i_clk);
    check("reset_busy", {31'd0, o_busy}, 32'd0);
    check("reset_valid", {31'd0, o_valid}, 32'd0);
    check("reset_result", o_result, 32'd0);
    i_rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 0, 0);

    run_op(2'b01, 32'd1000, 32'd10, 32'd100, 35, 10, 0);
    run_op(2'b01, 32'd1000, 32'd10, 32'd0, 35, 0, 15);
    repeat (2) @(negedge i_clk);
    check("rst_hold_valid", {31'd0, o_valid}, 32'd0);
    i_rst_n = 1'b1;
    run_op(2'b01, 32'd9, 32'd3, 32'd3, 35, 0, 0);

    repeat (3) @(negedge i_clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
